sprite_layer_renderer: RTL and testbench
========================================

Name: sprite_layer_renderer

Overview:
Parametrised two-layer pixel renderer: a scrolled, upscaled background map with one animated, direction-facing sprite composited on top, with transparency. Sits between the VGA timing generator (DrawX/DrawY/VS) and the palette LUT. It owns the walk-animation FSM and drives the read addresses of the sprite-sheet RAM and the map RAM. Both RAMs are external, synchronous-read, with 1-cycle latency. Animation state advances only on a synchronised VS rising edge inside the Clk domain.

Parameters:
SPR_W, 19, sprite frame width in pixels
SPR_H, 29, sprite frame height in pixels
SHEET_W, 228, sprite-sheet row pitch in pixels (12 frames x SPR_W)
POS_X, 311, screen X of sprite top-left
POS_Y, 340, screen Y of sprite top-left
TRANSP_IDX, 6, sheet palette index treated as transparent
STEP_VSYNCS, 8, VS ticks per animation phase step (>=1)
MAP_W, 320, map row pitch in map texels
SCALE_SHIFT, 1, map upscale: one texel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT pixels
ADDR_W, 13, Sheet_Addr width
MAP_ADDR_W, 17, Map_Addr width
IDX_W, 6, palette index width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
VS  in  1  vertical sync (async to logic; synchronised internally)
Moving  in  1  character walking request
Direction  in  2  0=up 1=right 2=down 3=left
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
Scroll_X  in  11  map scroll offset X (pixels)
Scroll_Y  in  11  map scroll offset Y (pixels)
Sheet_Addr  out  ADDR_W  sprite-sheet RAM read address
Sheet_Data  in  IDX_W  sheet RAM data, 1 cycle after address
Map_Addr  out  MAP_ADDR_W  map RAM read address
Map_Data  in  IDX_W  map RAM data, 1 cycle after address
Pix_Idx  out  IDX_W  composited palette index
Char_Hit  out  1  sprite window hit, aligned with Pix_Idx
Anim_Dir  out  2  current facing (Direction encoding)
Anim_Phase  out  2  current walk phase 0..3

Behaviour:
- Reset values: state IDLE, Anim_Dir=0 (up), Anim_Phase=0, divider=0, Pix_Idx=0, Char_Hit=0, pipeline hit flag=0.
- Reset values of the VS synchroniser: 2 flops plus prev flop all reset to 1. VS held high through Reset release gives no tick. A tick needs VS low, then high.
- frame_tick: one Clk pulse on the synchronised VS 0->1 edge. Latency is 3 Clk from the VS edge.
- FSM states IDLE and WALK. All inputs are sampled only on frame_tick; between ticks the state is frozen.
- On tick with Moving=0: state->IDLE, phase<=0, divider<=0, dir held.
- On tick with Moving=1 and Direction!=dir: dir<=Direction, phase<=0, divider<=0, state->WALK.
- On tick with Moving=1 and Direction==dir: state->WALK. If divider==STEP_VSYNCS-1 then divider<=0 and phase<=phase+1 (3 wraps to 0); otherwise divider++.
- Phase-to-column map: phase 0->1 (rest), 1->0 (M1), 2->1 (rest), 3->2 (M2).
- Direction-to-sheet-block map: down=0, left=1, up=2, right=3. Each block is 3 columns wide.
- col = 3*block(dir) + phase_col(phase). col_off = col*SPR_W.
- hit = (POS_X <= DrawX <= POS_X+SPR_W-1) && (POS_Y <= DrawY <= POS_Y+SPR_H-1), bounds inclusive.
- Sheet_Addr (combinational): SHEET_W*(DrawY-POS_Y) + (DrawX-POS_X) + col_off when hit, else 0.
- Map_Addr (combinational, always driven, including under the sprite): ((DrawY+Scroll_Y)>>SCALE_SHIFT)*MAP_W + ((DrawX+Scroll_X)>>SCALE_SHIFT).
- Map_Addr arithmetic: sums are 12-bit; the result is truncated to MAP_ADDR_W.
- Pipeline stage 1: register hit into hit_d. RAM data arrives in the same cycle.
- Pipeline stage 2: if hit_d && Sheet_Data!=TRANSP_IDX then Pix_Idx<=Sheet_Data, else Pix_Idx<=Map_Data. Char_Hit<=hit_d.
- Total latency DrawX/DrawY -> Pix_Idx/Char_Hit is 2 Clk.
- Reset mid-line flushes the pipeline to 0 and returns the FSM to IDLE/up/phase 0.

Decomposition:
- Package sprite_pkg holds:
  - dir_t enum (UP, RIGHT, DOWN, LEFT)
  - anim_state_t (IDLE, WALK)
  - phase_col function/table
  - dir_block function
  - COLS_PER_DIR=3 and WALK_PHASES=4
- Sub-module sprite_anim_fsm holds the VS synchroniser, edge detect, divider and FSM. It outputs dir and phase.

Test Plan:
- Reset, DrawX=311, DrawY=340 -> Sheet_Addr=133; Anim_Dir=0, Anim_Phase=0; Pix_Idx=0 until pipeline fills.
- STEP_VSYNCS=1, Moving=1, Direction=0, 5 VS pulses -> Sheet_Addr at (311,340) = 133, 114, 133, 152, 133.
- Moving=1, Direction=1 at tick -> Anim_Dir=1, phase 0; (311,340) gives 190; (329,368) gives 6592; (330,368) gives Char_Hit=0 and Sheet_Addr=0.
- In window, Sheet_Data=6 and Map_Data=17 -> Pix_Idx=17 two cycles later. Sheet_Data=3 -> Pix_Idx=3 with Char_Hit=1.
- DrawX=100, DrawY=50, Scroll_X=20, Scroll_Y=10 -> Map_Addr=9660, Char_Hit=0.
- Toggle Moving/Direction with no VS edge -> no state change. VS high across Reset release -> no tick until VS falls and rises again.
- STEP_VSYNCS=8 default -> phase advances on every 8th tick only.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and sheet-layout helpers for the sprite layer renderer.
// The sheet is laid out as four direction blocks of three walk columns each.
package sprite_pkg;

  localparam int COLS_PER_DIR = 3;
  localparam int WALK_PHASES  = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } anim_state_t;

  // Walk cycle is rest, M1, rest, M2; the rest pose sits in the middle column.
  function automatic logic [1:0] phase_col(input logic [1:0] phase);
    logic [1:0] col;
    case (phase)
      2'd0:    col = 2'd1;
      2'd1:    col = 2'd0;
      2'd2:    col = 2'd1;
      default: col = 2'd2;
    endcase
    return col;
  endfunction

  function automatic logic [1:0] dir_block(input dir_t dir);
    logic [1:0] blk;
    case (dir)
      DIR_DOWN:  blk = 2'd0;
      DIR_LEFT:  blk = 2'd1;
      DIR_UP:    blk = 2'd2;
      default:   blk = 2'd3;
    endcase
    return blk;
  endfunction

endpackage

// File: rtl/sprite_layer_renderer_anim_fsm.sv
// Walk-animation controller: VS synchroniser, rising-edge detect, step divider
// and IDLE/WALK state machine. State only moves on a frame tick.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int STEP_VSYNCS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       VS,
  input  logic       Moving,
  input  logic [1:0] Direction,
  output dir_t       anim_dir,
  output logic [1:0] anim_phase
);

  localparam int DIV_W = (STEP_VSYNCS > 1) ? $clog2(STEP_VSYNCS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_VSYNCS - 1);

  logic             vs_sync1_q, vs_sync1_d;
  logic             vs_sync2_q, vs_sync2_d;
  logic             vs_prev_q,  vs_prev_d;
  logic             frame_tick;
  anim_state_t      state_q,  state_d;
  dir_t             dir_q,    dir_d;
  logic [1:0]       phase_q,  phase_d;
  logic [DIV_W-1:0] div_q,    div_d;

  // Synchroniser resets high so a VS already high at reset release is not an edge.
  assign frame_tick = vs_sync2_q & ~vs_prev_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    vs_sync1_d = VS;
    vs_sync2_d = vs_sync1_q;
    vs_prev_d  = vs_sync2_q;
    state_d    = state_q;
    dir_d      = dir_q;
    phase_d    = phase_q;
    div_d      = div_q;
    if (frame_tick) begin
      if (!Moving) begin
        state_d = ST_IDLE;
        phase_d = '0;
        div_d   = '0;
      end else if (dir_t'(Direction) != dir_q) begin
        state_d = ST_WALK;
        dir_d   = dir_t'(Direction);
        phase_d = '0;
        div_d   = '0;
      end else begin
        state_d = ST_WALK;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = (phase_q == 2'(WALK_PHASES - 1)) ? 2'd0 : phase_q + 2'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_sync1_q <= 1'b1;
      vs_sync2_q <= 1'b1;
      vs_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      dir_q      <= DIR_UP;
      phase_q    <= '0;
      div_q      <= '0;
    end else begin
      vs_sync1_q <= vs_sync1_d;
      vs_sync2_q <= vs_sync2_d;
      vs_prev_q  <= vs_prev_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
    end
  end

  assign anim_dir   = dir_q;
  assign anim_phase = phase_q;

endmodule

// File: rtl/sprite_layer_renderer.sv
// Two-layer renderer: scrolled, upscaled map with one animated sprite on top.
// Drives both RAM read addresses combinationally; output is 2 Clk behind DrawX/DrawY.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 19,
  parameter int SPR_H       = 29,
  parameter int SHEET_W     = 228,
  parameter int POS_X       = 311,
  parameter int POS_Y       = 340,
  parameter int TRANSP_IDX  = 6,
  parameter int STEP_VSYNCS = 8,
  parameter int MAP_W       = 320,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 13,
  parameter int MAP_ADDR_W  = 17,
  parameter int IDX_W       = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  VS,
  input  logic                  Moving,
  input  logic [1:0]            Direction,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic [10:0]           Scroll_X,
  input  logic [10:0]           Scroll_Y,
  output logic [ADDR_W-1:0]     Sheet_Addr,
  input  logic [IDX_W-1:0]      Sheet_Data,
  output logic [MAP_ADDR_W-1:0] Map_Addr,
  input  logic [IDX_W-1:0]      Map_Data,
  output logic [IDX_W-1:0]      Pix_Idx,
  output logic                  Char_Hit,
  output logic [1:0]            Anim_Dir,
  output logic [1:0]            Anim_Phase
);

  localparam logic [9:0] X_LO = 10'(POS_X);
  localparam logic [9:0] X_HI = 10'(POS_X + SPR_W - 1);
  localparam logic [9:0] Y_LO = 10'(POS_Y);
  localparam logic [9:0] Y_HI = 10'(POS_Y + SPR_H - 1);

  dir_t              anim_dir;
  logic [1:0]        anim_phase;
  logic [3:0]        col;
  logic [ADDR_W-1:0] col_off;
  logic [9:0]        rel_x, rel_y;
  logic              hit;
  logic [11:0]       sum_x, sum_y, tex_x, tex_y;

  logic              hit_s1_q,   hit_s1_d;
  logic [IDX_W-1:0]  pix_idx_q,  pix_idx_d;
  logic              char_hit_q, char_hit_d;

  sprite_anim_fsm #(
    .STEP_VSYNCS (STEP_VSYNCS)
  ) u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .VS         (VS),
    .Moving     (Moving),
    .Direction  (Direction),
    .anim_dir   (anim_dir),
    .anim_phase (anim_phase)
  );

  assign col     = 4'(COLS_PER_DIR) * {2'b00, dir_block(anim_dir)} + {2'b00, phase_col(anim_phase)};
  assign col_off = ADDR_W'(col) * ADDR_W'(SPR_W);

  assign hit   = (DrawX >= X_LO) && (DrawX <= X_HI) && (DrawY >= Y_LO) && (DrawY <= Y_HI);
  assign rel_x = DrawX - X_LO;
  assign rel_y = DrawY - Y_LO;

  assign Sheet_Addr = hit ? (ADDR_W'(rel_y) * ADDR_W'(SHEET_W) + ADDR_W'(rel_x) + col_off)
                          : '0;

  // Map sums wrap at 12 bits; the final product wraps at the map address width.
  assign sum_x    = {2'b00, DrawX} + {1'b0, Scroll_X};
  assign sum_y    = {2'b00, DrawY} + {1'b0, Scroll_Y};
  assign tex_x    = sum_x >> SCALE_SHIFT;
  assign tex_y    = sum_y >> SCALE_SHIFT;
  assign Map_Addr = MAP_ADDR_W'(tex_y) * MAP_ADDR_W'(MAP_W) + MAP_ADDR_W'(tex_x);

  // RAM data for the stage-1 address is valid while hit_s1_q is, so compose here.
  always_comb begin
    hit_s1_d   = hit;
    char_hit_d = hit_s1_q;
    pix_idx_d  = Map_Data;
    if (hit_s1_q && (Sheet_Data != IDX_W'(TRANSP_IDX))) begin
      pix_idx_d = Sheet_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_s1_q   <= 1'b0;
      pix_idx_q  <= '0;
      char_hit_q <= 1'b0;
    end else begin
      hit_s1_q   <= hit_s1_d;
      pix_idx_q  <= pix_idx_d;
      char_hit_q <= char_hit_d;
    end
  end

  assign Pix_Idx    = pix_idx_q;
  assign Char_Hit   = char_hit_q;
  assign Anim_Dir   = anim_dir;
  assign Anim_Phase = anim_phase;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench: one renderer with a 1-tick animation step, one with the default 8.
// Both share all inputs; the bench plays the role of both RAMs.
module tb_sprite_layer_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        VS;
  logic        Moving;
  logic [1:0]  Direction;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] Scroll_X, Scroll_Y;
  logic [5:0]  Sheet_Data, Map_Data;

  logic [12:0] sheet_addr_a, sheet_addr_b;
  logic [16:0] map_addr_a,   map_addr_b;
  logic [5:0]  pix_idx_a,    pix_idx_b;
  logic        char_hit_a,   char_hit_b;
  logic [1:0]  anim_dir_a,   anim_dir_b;
  logic [1:0]  anim_phase_a, anim_phase_b;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  sprite_layer_renderer #(.STEP_VSYNCS(1)) dut_fast (
    .Clk(Clk), .Reset(Reset), .VS(VS), .Moving(Moving), .Direction(Direction),
    .DrawX(DrawX), .DrawY(DrawY), .Scroll_X(Scroll_X), .Scroll_Y(Scroll_Y),
    .Sheet_Addr(sheet_addr_a), .Sheet_Data(Sheet_Data),
    .Map_Addr(map_addr_a), .Map_Data(Map_Data),
    .Pix_Idx(pix_idx_a), .Char_Hit(char_hit_a),
    .Anim_Dir(anim_dir_a), .Anim_Phase(anim_phase_a)
  );

  sprite_layer_renderer dut_slow (
    .Clk(Clk), .Reset(Reset), .VS(VS), .Moving(Moving), .Direction(Direction),
    .DrawX(DrawX), .DrawY(DrawY), .Scroll_X(Scroll_X), .Scroll_Y(Scroll_Y),
    .Sheet_Addr(sheet_addr_b), .Sheet_Data(Sheet_Data),
    .Map_Addr(map_addr_b), .Map_Data(Map_Data),
    .Pix_Idx(pix_idx_b), .Char_Hit(char_hit_b),
    .Anim_Dir(anim_dir_b), .Anim_Phase(anim_phase_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  // Falling then rising VS; the tick lands within 3 Clk of the rise.
  task automatic vs_pulse();
    VS = 1'b0;
    cycles(4);
    VS = 1'b1;
    cycles(5);
  endtask

  initial begin
    Reset = 1'b1; VS = 1'b1; Moving = 1'b0; Direction = 2'd0;
    DrawX = 10'd311; DrawY = 10'd340; Scroll_X = '0; Scroll_Y = '0;
    Sheet_Data = 6'd0; Map_Data = 6'd0;
    cycles(3);
    check("rst_pix", pix_idx_a, 0);
    check("rst_hit", char_hit_a, 0);

    // VS held high through release, inputs toggled: nothing may move.
    Reset = 1'b0; Moving = 1'b1; Direction = 2'd3;
    #1;
    check("rst_sheet_addr", sheet_addr_a, 133);
    check("rst_dir", anim_dir_a, 0);
    check("rst_phase", anim_phase_a, 0);
    cycles(1);
    check("fill_hit_1clk", char_hit_a, 0);
    cycles(1);
    check("fill_hit_2clk", char_hit_a, 1);
    Direction = 2'd1;
    cycles(8);
    check("no_edge_dir", anim_dir_a, 0);
    check("no_edge_phase", anim_phase_a, 0);
    check("no_edge_dir_slow", anim_dir_b, 0);

    // Walk up, one phase per tick on the fast instance.
    Direction = 2'd0;
    vs_pulse(); check("walk_p1", sheet_addr_a, 114);
    vs_pulse(); check("walk_p2", sheet_addr_a, 133);
    vs_pulse(); check("walk_p3", sheet_addr_a, 152);
    vs_pulse(); check("walk_p0", sheet_addr_a, 133);
    check("walk_phase_wrap", anim_phase_a, 0);
    check("slow_phase_4ticks", anim_phase_b, 0);
    check("slow_addr_4ticks", sheet_addr_b, 133);

    // Turn right: new facing, phase restarts.
    Direction = 2'd1;
    vs_pulse();
    check("turn_dir", anim_dir_a, 1);
    check("turn_phase", anim_phase_a, 0);
    check("turn_addr", sheet_addr_a, 190);
    check("turn_dir_slow", anim_dir_b, 1);
    DrawX = 10'd329; DrawY = 10'd368; #1;
    check("corner_addr", sheet_addr_a, 6592);
    cycles(2);
    check("corner_hit", char_hit_a, 1);
    DrawX = 10'd330; #1;
    check("outside_addr", sheet_addr_a, 0);
    cycles(2);
    check("outside_hit", char_hit_a, 0);
    DrawX = 10'd311; DrawY = 10'd339; #1;
    check("above_addr", sheet_addr_a, 0);

    // Compositing: transparent sheet index shows the map beneath.
    DrawX = 10'd320; DrawY = 10'd350; Sheet_Data = 6'd6; Map_Data = 6'd17;
    cycles(2);
    check("transp_pix", pix_idx_a, 17);
    check("transp_hit", char_hit_a, 1);
    Sheet_Data = 6'd3;
    cycles(2);
    check("opaque_pix", pix_idx_a, 3);
    check("opaque_hit", char_hit_a, 1);

    // Map addressing, off-sprite and at the 12-bit / address-width wrap.
    DrawX = 10'd100; DrawY = 10'd50; Scroll_X = 11'd20; Scroll_Y = 11'd10; #1;
    check("map_addr", map_addr_a, 9660);
    cycles(2);
    check("map_hit", char_hit_a, 0);
    check("map_pix", pix_idx_a, 17);
    DrawX = 10'd311; DrawY = 10'd340; Scroll_X = '0; Scroll_Y = '0; #1;
    check("map_under_sprite", map_addr_a, 54555);
    DrawX = 10'd1023; DrawY = 10'd1023; Scroll_X = 11'd2047; Scroll_Y = 11'd2047; #1;
    check("map_wrap", map_addr_a, 99519);
    DrawX = 10'd311; DrawY = 10'd340; Scroll_X = '0; Scroll_Y = '0;

    // Default divider: phase steps only on the 8th same-direction tick.
    repeat (7) vs_pulse();
    check("slow_7ticks", anim_phase_b, 0);
    vs_pulse();
    check("slow_8ticks", anim_phase_b, 1);
    check("slow_8ticks_addr", sheet_addr_b, 171);

    // Stop: phase clears, facing is kept.
    Moving = 1'b0;
    vs_pulse();
    check("stop_phase", anim_phase_b, 0);
    check("stop_dir", anim_dir_b, 1);

    // Mid-line reset flushes the pipeline and the animation state.
    Moving = 1'b1; Sheet_Data = 6'd3;
    cycles(2);
    check("pre_reset_pix", pix_idx_a, 3);
    Reset = 1'b1;
    cycles(1);
    check("midreset_pix", pix_idx_a, 0);
    check("midreset_hit", char_hit_a, 0);
    check("midreset_dir", anim_dir_a, 0);
    Reset = 1'b0; Direction = 2'd2;
    cycles(6);
    check("post_reset_no_tick", anim_dir_a, 0);
    vs_pulse();
    check("post_reset_tick_dir", anim_dir_a, 2);
    check("post_reset_tick_addr", sheet_addr_a, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
